muldiv_seq_ctrl: RTL

- Control FSM for the iterative unsigned multiplier/divider datapath in ALU/MultiplierDivider.
- Sequences three shift-register instances:
  - A: accumulator/remainder.
  - Q: multiplier/dividend/quotient.
  - M: multiplicand/divisor.
- Drives their clear/sample/shift/newBit controls from datapath status bits, one result bit per cycle.
- Sits between the ALU issue logic (start/done handshake) and the register datapath. Holds no operand data itself.

---
 rtl/muldiv_pkg.sv | 33 +++
 rtl/muldiv_iter_counter.sv | 28 ++
 rtl/muldiv_seq_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide sequencer.
package muldiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } muldiv_state_t;

  typedef enum logic [1:0] {
    MULU_LO = 2'd0,
    MULU_HI = 2'd1,
    DIVU    = 2'd2,
    REMU    = 2'd3
  } muldiv_op_t;

  localparam logic ASEL_SUM   = 1'b0;
  localparam logic ASEL_TRIAL = 1'b1;

  // High product word and remainder end up in A; low product and quotient in Q.
  function automatic logic result_in_a(input muldiv_op_t op);
    logic sel;
    case (op)
      MULU_HI: sel = 1'b1;
      REMU:    sel = 1'b1;
      MULU_LO: sel = 1'b0;
      DIVU:    sel = 1'b0;
      default: sel = 1'b0;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/muldiv_iter_counter.sv
// Iteration counter for the multiply/divide loop with terminal-count flag.
module muldiv_iter_counter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_last
);

  logic [CNT_W-1:0] r_cnt;

  // Count loop iterations; clear has priority over enable.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_last = (r_cnt == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/muldiv_seq_ctrl.sv
// Control FSM for the shift-add multiplier / restoring divider: one result bit
// per RUN cycle, driving A/Q/M register controls from datapath status.
module muldiv_seq_ctrl
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [1:0] i_op,
  input  logic       i_flush,
  input  logic       i_op_b_zero,
  output logic       o_ready,
  output logic       o_done,
  output logic       o_result_sel,
  output logic       o_div_by_zero,
  input  logic       i_q_lsb,
  input  logic       i_q_msb,
  input  logic       i_a_lsb,
  input  logic       i_sum_lsb,
  input  logic       i_trial_ge,
  output logic       o_a_clear,
  output logic       o_a_sample_en,
  output logic       o_a_shift_left,
  output logic       o_a_shift_right,
  output logic       o_a_newbit,
  output logic       o_a_sel,
  output logic       o_q_sample_en,
  output logic       o_q_shift_left,
  output logic       o_q_shift_right,
  output logic       o_q_newbit,
  output logic       o_m_sample_en
);

  muldiv_state_t r_state;
  muldiv_state_t w_next;
  muldiv_op_t    r_op;
  logic          r_dbz;
  logic          w_accept;
  logic          w_cnt_clr;
  logic          w_cnt_en;
  logic          w_last;
  logic          w_is_div;

  muldiv_iter_counter #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (w_cnt_clr),
    .i_en  (w_cnt_en),
    .o_last(w_last)
  );

  assign w_is_div = (r_op == DIVU) || (r_op == REMU);

  // State register plus operation/divide-by-zero latch captured on accept.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_op    <= MULU_LO;
      r_dbz   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op  <= muldiv_op_t'(i_op);
        r_dbz <= i_op[1] & i_op_b_zero;
      end else begin
        r_op  <= r_op;
        r_dbz <= r_dbz;
      end
    end
  end

  // Next-state and register-control decode; flush overrides everything but reset.
  always_comb begin
    w_next          = r_state;
    w_accept        = 1'b0;
    w_cnt_clr       = 1'b0;
    w_cnt_en        = 1'b0;
    o_a_clear       = 1'b0;
    o_a_sample_en   = 1'b0;
    o_a_shift_left  = 1'b0;
    o_a_shift_right = 1'b0;
    o_a_newbit      = 1'b0;
    o_a_sel         = ASEL_SUM;
    o_q_sample_en   = 1'b0;
    o_q_shift_left  = 1'b0;
    o_q_shift_right = 1'b0;
    o_q_newbit      = 1'b0;
    o_m_sample_en   = 1'b0;
    if (i_rst) begin
      w_next = IDLE;
    end else if (i_flush) begin
      w_next    = IDLE;
      w_cnt_clr = 1'b1;
      o_a_clear = 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          w_cnt_clr = 1'b1;
          if (i_start) begin
            w_accept      = 1'b1;
            o_a_clear     = 1'b1;
            o_q_sample_en = 1'b1;
            o_m_sample_en = 1'b1;
            w_next        = (i_op[1] && i_op_b_zero) ? DONE : RUN;
          end else begin
            w_next = IDLE;
          end
        end
        RUN: begin
          w_cnt_en = 1'b1;
          w_next   = w_last ? DONE : RUN;
          if (w_is_div) begin
            o_q_shift_left = 1'b1;
            if (i_trial_ge) begin
              o_a_sample_en = 1'b1;
              o_a_sel       = ASEL_TRIAL;
              o_q_newbit    = 1'b1;
            end else begin
              o_a_shift_left = 1'b1;
              o_a_newbit     = i_q_msb;
            end
          end else begin
            o_q_shift_right = 1'b1;
            if (i_q_lsb) begin
              o_a_sample_en = 1'b1;
              o_a_sel       = ASEL_SUM;
              o_q_newbit    = i_sum_lsb;
            end else begin
              o_a_shift_right = 1'b1;
              o_a_newbit      = 1'b0;
              o_q_newbit      = i_a_lsb;
            end
          end
        end
        DONE: begin
          w_next = IDLE;
        end
        default: begin
          w_next = IDLE;
        end
      endcase
    end
  end

  assign o_ready       = (r_state == IDLE);
  assign o_done        = (r_state == DONE) & ~i_flush & ~i_rst;
  assign o_result_sel  = o_done & result_in_a(r_op);
  assign o_div_by_zero = o_done & r_dbz;

endmodule
